seq_normalizer: RTL
===================

// Module: seq_normalizer
// PURPOSE
//  Iterative normalizer: the inverse of the combinational barrel shifter.
//  Takes a word and shifts it one bit per clock until the target end bit is 1.
//  Target is the MSB for left normalize and the LSB for right normalize.
//  Reports the normalized word and the shift amount that was applied.
//  Feeding out_out and amt_out back through the barrel shifter in the opposite
//  direction reproduces a_in.
//  Sits in the datapath ahead of the shifter (leading-zero/trailing-zero count).
// PARAMETERS
//  WIDTH  8  data width in bits
//  AMT_W  3  shift-amount width; must satisfy 2**AMT_W >= WIDTH
// PORTS
//  clk_in    in   1      single clock; all logic on its rising edge
//  rst_n_in  in   1      asynchronous, active-low reset
//  start_in  in   1      request; accepted when busy_out==0
//  a_in      in   WIDTH  operand, sampled on the accepting edge
//  dir_in    in   1      0 = normalize left (to MSB), 1 = normalize right (to LSB); sampled with a_in
//  busy_out  out  1      high while an operation is in progress
//  done_out  out  1      one-cycle completion pulse
//  out_out   out  WIDTH  normalized word
//  amt_out   out  AMT_W  number of bit positions shifted
//  zero_out  out  1      operand was all-zero
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; busy_out, done_out, out_out, amt_out and zero_out all 0.
//   - Asserting reset mid-operation aborts the operation; no done_out pulse is produced.
//  States:
//   - IDLE: if start_in, load the work register with a_in, latch dir_in, set count=0,
//     busy_out<=1, go to SHIFT.
//   - SHIFT, checked each cycle:
//     - work==0: result complete, zero_out=1.
//     - target bit (work[WIDTH-1] for left, work[0] for right) ==1: result complete, zero_out=0.
//     - otherwise: shift work one place toward the target end, fill with 0, count++, stay in SHIFT.
//   - On completion, at the same edge: out_out<=work, amt_out<=count, zero_out updated,
//     done_out<=1 for exactly one cycle, busy_out<=0, state returns to IDLE.
//  Latency:
//   - For a needed shift of n (0..WIDTH-1), done_out is high in the cycle after edge n+1,
//     where edge 0 is the accepting edge.
//   - A zero operand completes in 1 cycle with out_out=0 and amt_out=0.
//  Handshake:
//   - start_in is ignored while busy_out=1; there is no queueing.
//   - start_in in the cycle done_out=1 is accepted, since busy_out is already 0.
//     Back-to-back operations therefore need no gap.
//   - a_in and dir_in matter only on the accepting edge.
//  Output holding:
//   - out_out, amt_out and zero_out change only at completion (or reset).
//   - They hold their values through the next operation until its completion.
//  Width rules:
//   - count never exceeds WIDTH-1, so it never wraps.
//   - A nonzero operand always terminates within WIDTH-1 shifts.
// TESTING
//  1. a=8'b00001111, dir=0 -> out=8'b11110000, amt=4, zero=0; done 5 cycles after start.
//  2. a=8'b00001111, dir=1 -> out=8'b00001111, amt=0; done 1 cycle after start.
//  3. a=8'b00000001, dir=0 -> out=8'b10000000, amt=7; done 8 cycles after start.
//     a=8'b10000000, dir=1 -> out=8'b00000001, amt=7.
//  4. a=0 (either dir) -> out=0, amt=0, zero=1; done 1 cycle after start.
//  5. start pulsed mid-operation with a different a -> ignored, first result intact.
//     start held in the done cycle -> second operation begins with no gap.
//  6. rst_n low at cycle 2 of the case-1 operation -> all outputs 0 at once, no done pulse.
//     Next start completes normally.
//  Random check: shift out_out by amt_out in the opposite direction through the barrel
//  shifter; the result must equal a_in for all 255 nonzero a_in, both directions.

Source files
------------

// File: rtl/seq_normalizer.sv
// Iterative normalizer: shifts an operand one bit per clock toward the MSB (left) or
// LSB (right) until that end bit is set, reporting the word, shift count and zero flag.
module seq_normalizer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic             dir_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] out_out,
  output logic [AMT_W-1:0] amt_out,
  output logic             zero_out
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             dir_q, dir_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             zero_q, zero_d;

  logic work_zero;
  logic target_hit;

  assign work_zero  = (work_q == '0);
  assign target_hit = dir_q ? work_q[0] : work_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dir_d   = dir_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    amt_d   = amt_q;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          work_d  = a_in;
          dir_d   = dir_in;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        // A nonzero word reaches its target bit within WIDTH-1 shifts, so count cannot wrap.
        if (work_zero || target_hit) begin
          out_d   = work_q;
          amt_d   = count_q;
          zero_d  = work_zero;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          work_d  = dir_q ? (work_q >> 1) : (work_q << 1);
          count_d = count_q + AMT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      work_q  <= '0;
      dir_q   <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      amt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      amt_q   <= amt_d;
      zero_q  <= zero_d;
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign out_out  = out_q;
  assign amt_out  = amt_q;
  assign zero_out = zero_q;

endmodule
